// File: rtl/edge_rate_monitor.sv
// Edge rate monitor: counts clk cycles between rising edges of an async strobe.
// Reports last/min/max period, event count and done/timeout status per run.
module edge_rate_monitor #(
    parameter int CNT_W       = 32,
    parameter int NUM_EVENTS  = 3,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ev_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic [CNT_W-1:0] ev_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] NEV      = CNT_W'(NUM_EVENTS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   ev_edge;
    logic                   start_ok;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       ev_next;

    assign ev_edge  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign start_ok = start && (state == IDLE || state == DONE);
    assign ev_next  = ev_count + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ev_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Cycles since the last start or edge; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start_ok || ev_edge) begin
            cnt <= ONE;
        end else if (cnt != ALL_ONES) begin
            cnt <= cnt + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            min_period   <= ALL_ONES;
            max_period   <= '0;
            ev_count     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= ARMED;
                        period     <= '0;
                        ev_count   <= '0;
                        min_period <= ALL_ONES;
                        max_period <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                ARMED: begin
                    if (ev_edge) begin
                        state <= MEASURE;
                    end else if (cnt == TMO) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                MEASURE: begin
                    // An edge landing on the timeout cycle still counts as a period.
                    if (ev_edge) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        ev_count     <= ev_next;
                        if (cnt < min_period) min_period <= cnt;
                        if (cnt > max_period) max_period <= cnt;
                        if (ev_next == NEV) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (cnt == TMO) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_edge_rate_monitor.sv
// Bench for edge_rate_monitor: directed and random edge schedules against
// a period-list model, on a wide instance and a 4-bit saturating instance.
module tb_edge_rate_monitor;
    logic clk = 1'b0;
    logic reset;
    logic start1, ev1, start2, ev2;

    logic [31:0] p1, min1, max1, cnt1;
    logic        pv1, busy1, done1, tmo1;
    logic [3:0]  p2, min2, max2, cnt2;
    logic        pv2, busy2, done2, tmo2;

    int n_chk = 0;
    int n_fail = 0;
    int sel = 0;

    logic [31:0] o_period, o_min, o_max, o_cnt;
    logic        o_pv, o_busy, o_done, o_tmo;

    int          dq[$];
    int          expq[$];
    logic [31:0] cap[$];

    always #5 clk = ~clk;

    edge_rate_monitor #(
        .CNT_W(32), .NUM_EVENTS(3), .TIMEOUT(50), .SYNC_STAGES(2)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ev_in(ev1),
        .period(p1), .period_valid(pv1), .min_period(min1),
        .max_period(max1), .ev_count(cnt1), .busy(busy1),
        .done(done1), .timeout(tmo1)
    );

    edge_rate_monitor #(
        .CNT_W(4), .NUM_EVENTS(3), .TIMEOUT(15), .SYNC_STAGES(2)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ev_in(ev2),
        .period(p2), .period_valid(pv2), .min_period(min2),
        .max_period(max2), .ev_count(cnt2), .busy(busy2),
        .done(done2), .timeout(tmo2)
    );

    always_comb begin
        if (sel == 0) begin
            o_period = p1;  o_min = min1; o_max = max1; o_cnt = cnt1;
            o_pv = pv1; o_busy = busy1; o_done = done1; o_tmo = tmo1;
        end else begin
            o_period = 32'(p2); o_min = 32'(min2);
            o_max = 32'(max2);  o_cnt = 32'(cnt2);
            o_pv = pv2; o_busy = busy2; o_done = done2; o_tmo = tmo2;
        end
    end

    always @(negedge clk) if (o_pv) cap.push_back(o_period);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag, input logic [31:0] ones);
        chk({tag, "_period"}, o_period, 32'd0);
        chk({tag, "_pv"}, 32'(o_pv), 32'd0);
        chk({tag, "_min"}, o_min, ones);
        chk({tag, "_max"}, o_max, 32'd0);
        chk({tag, "_count"}, o_cnt, 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_tmo"}, 32'(o_tmo), 32'd0);
    endtask

    // dq holds edge detection times in cycles after the accepted start.
    task automatic run(input string tag, input int s, input int busy_k,
                       input int abort_k);
        int tmo_lim, prev, v, fin, ecount, lastk, kend, bk;
        int rk[$];
        logic [31:0] maxv, emin, emax, eper;
        bit etmo, st, evv;
        sel = s;
        maxv = (s != 0) ? 32'hF : 32'hFFFF_FFFF;
        tmo_lim = (s != 0) ? 15 : 50;
        expq.delete();
        rk.delete();
        etmo = 0; ecount = 0; emin = maxv; emax = 0; eper = 0;
        prev = 1; fin = -1;
        foreach (dq[i]) begin
            rk.push_back(dq[i] - 2);
            if (fin < 0) begin
                v = dq[i] + 1 - prev;
                if (v > tmo_lim) begin
                    fin = prev + tmo_lim;
                    etmo = 1;
                end else begin
                    if (i > 0) begin
                        expq.push_back(v);
                        ecount++;
                        eper = 32'(v);
                        if (32'(v) < emin) emin = 32'(v);
                        if (32'(v) > emax) emax = 32'(v);
                    end
                    prev = dq[i] + 1;
                    if (ecount == 3) fin = prev;
                end
            end
        end
        if (fin < 0) begin
            fin = prev + tmo_lim;
            etmo = 1;
        end
        lastk = (rk.size() > 0) ? rk[rk.size()-1] : 0;
        kend = ((lastk > fin) ? lastk : fin) + 6;
        bk = busy_k;
        if (busy_k == -2) bk = int'($urandom_range(fin - 1, 1));
        cap.delete();
        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                #2 reset = 1'b1;
                #1 chk_reset({tag, "_rst"}, maxv);
                @(negedge clk);
                reset = 1'b0;
                start1 = 0; ev1 = 0; start2 = 0; ev2 = 0;
                repeat (4) @(negedge clk);
                return;
            end
            if (k == fin - 1) chk({tag, "_done_early"}, 32'(o_done), 32'd0);
            if (k == fin) begin
                chk({tag, "_done_time"}, 32'(o_done), 32'd1);
                chk({tag, "_tmo_time"}, 32'(o_tmo), 32'(etmo));
            end
            st = (k == 0) || (k == bk);
            evv = 0;
            foreach (rk[j]) if (k >= rk[j] && k < rk[j] + 2) evv = 1;
            if (s == 0) begin
                start1 = st; ev1 = evv;
            end else begin
                start2 = st; ev2 = evv;
            end
        end
        start1 = 0; ev1 = 0; start2 = 0; ev2 = 0;
        @(negedge clk);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_tmo"}, 32'(o_tmo), 32'(etmo));
        chk({tag, "_count"}, o_cnt, 32'(ecount));
        chk({tag, "_period"}, o_period, eper);
        chk({tag, "_min"}, o_min, emin);
        chk({tag, "_max"}, o_max, emax);
        chk({tag, "_npv"}, 32'(cap.size()), 32'(expq.size()));
        foreach (expq[i])
            if (i < cap.size()) chk({tag, "_pvval"}, cap[i], 32'(expq[i]));
    endtask

    initial begin
        int n, t;
        reset = 1'b1;
        start1 = 0; ev1 = 0; start2 = 0; ev2 = 0;
        repeat (3) @(negedge clk);
        chk_reset("reset", 32'hFFFF_FFFF);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        dq = '{5, 15, 25, 35, 45};
        run("sq10", 0, -1, -1);
        dq = '{4, 12, 24, 30};
        run("spaced", 0, 15, -1);
        dq = '{};
        run("idle_tmo", 0, -1, -1);
        dq = '{5, 55, 105, 155};
        run("edge_at_tmo", 0, -1, -1);
        dq = '{5, 15, 66};
        run("gap_tmo", 0, -1, -1);
        dq = '{5, 15, 25, 35};
        run("midrst", 0, -1, 30);
        dq = '{5, 15, 25, 35};
        run("after_rst", 0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            dq.delete();
            n = int'($urandom_range(5, 0));
            t = int'($urandom_range(55, 3));
            for (int i = 0; i < n; i++) begin
                dq.push_back(t);
                t += int'($urandom_range(55, 5));
            end
            run("rand", 0, -2, -1);
        end

        dq = '{3, 18, 33, 48};
        run("sat15", 1, 20, -1);
        dq = '{3, 17, 33};
        run("sat_tmo", 1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
